// File: rtl/emulib_dmamodel_axi_responder.sv
// AXI4 slave that turns each burst beat into a single-word access on a
// synchronous SRAM-style port; one burst in flight, round-robin AW/AR grant.
module emulib_dmamodel_axi_responder #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned MEM_AW     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    mem_en,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    output logic [MEM_AW-1:0]       mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int unsigned SW = DATA_WIDTH / 8;
    localparam int unsigned LB = $clog2(SW);

    typedef enum logic [2:0] {IDLE, WDATA, WRESP, RADDR, RDATA} state_t;

    state_t                  state_q, state_d;
    logic [ID_WIDTH-1:0]     id_q;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_nxt, step, wrap_mask;
    logic [7:0]              len_q, g_len;
    logic [2:0]              size_q, g_size;
    logic [1:0]              burst_q, g_burst;
    logic [8:0]              beat_q;
    logic                    err_q, rr_last_rd, rd_first;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    grant_w, grant_r, grant_err, w_hs, r_hs;
    logic                    beat_ok, last_beat;

    assign beat_ok   = beat_q <= {1'b0, len_q};
    assign last_beat = beat_q == {1'b0, len_q};

    assign g_len   = grant_w ? s_axi_awlen   : s_axi_arlen;
    assign g_size  = grant_w ? s_axi_awsize  : s_axi_arsize;
    assign g_burst = grant_w ? s_axi_awburst : s_axi_arburst;
    assign grant_err = (g_size > 3'(LB)) || (g_burst == 2'b11) ||
                       ((g_burst == 2'b10) && !(g_len inside {8'd1, 8'd3, 8'd7, 8'd15}));

    // Next beat address: FIXED holds, WRAP folds inside the aligned container, else INCR
    always_comb begin
        step      = ADDR_WIDTH'(1) << size_q;
        wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
        case (burst_q)
            2'b00:   addr_nxt = addr_q;
            2'b10:   addr_nxt = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
            default: addr_nxt = addr_q + step;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        s_axi_awready = 1'b0;
        s_axi_arready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        s_axi_rvalid  = 1'b0;
        mem_en        = 1'b0;
        mem_wstrb     = '0;
        mem_wdata     = '0;
        grant_w       = 1'b0;
        grant_r       = 1'b0;
        w_hs          = 1'b0;
        r_hs          = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rst) begin
                    grant_w = s_axi_awvalid && (!s_axi_arvalid || rr_last_rd);
                    grant_r = s_axi_arvalid && !grant_w;
                end
                s_axi_awready = grant_w;
                s_axi_arready = grant_r;
                if (grant_w)      state_d = WDATA;
                else if (grant_r) state_d = RADDR;
            end
            WDATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid) begin
                    w_hs = 1'b1;
                    if (beat_ok && !err_q) begin
                        mem_en    = 1'b1;
                        mem_wstrb = s_axi_wstrb;
                        mem_wdata = s_axi_wdata;
                    end
                    if (s_axi_wlast) state_d = WRESP;
                end
            end
            WRESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) state_d = IDLE;
            end
            RADDR: begin
                mem_en  = !err_q;
                state_d = RDATA;
            end
            RDATA: begin
                s_axi_rvalid = 1'b1;
                if (s_axi_rready) begin
                    r_hs    = 1'b1;
                    state_d = last_beat ? IDLE : RADDR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            beat_q     <= '0;
            err_q      <= 1'b0;
            rr_last_rd <= 1'b1;
            rd_first   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            if (grant_w || grant_r) begin
                id_q       <= grant_w ? s_axi_awid : s_axi_arid;
                addr_q     <= grant_w ? s_axi_awaddr : s_axi_araddr;
                len_q      <= g_len;
                size_q     <= g_size;
                burst_q    <= g_burst;
                beat_q     <= '0;
                err_q      <= grant_err;
                rr_last_rd <= grant_r;
            end
            // Beat counter saturates at len+1 so overrun beats stay flagged
            if (w_hs) begin
                if (beat_ok) beat_q <= beat_q + 9'd1;
                addr_q <= addr_nxt;
                if (!beat_ok || (s_axi_wlast && !last_beat)) err_q <= 1'b1;
            end
            if (r_hs && !last_beat) begin
                beat_q <= beat_q + 9'd1;
                addr_q <= addr_nxt;
            end
            // First RDATA cycle passes the SRAM output through, then holds a copy
            if (state_q == RADDR) begin
                rd_first <= 1'b1;
            end else if (rd_first) begin
                rd_first <= 1'b0;
                rdata_q  <= err_q ? '0 : mem_rdata;
            end
        end
    end

    assign s_axi_bid   = id_q;
    assign s_axi_bresp = err_q ? 2'b10 : 2'b00;
    assign s_axi_rid   = id_q;
    assign s_axi_rresp = err_q ? 2'b10 : 2'b00;
    assign s_axi_rlast = (state_q == RDATA) && last_beat;
    assign s_axi_rdata = rd_first ? (err_q ? '0 : mem_rdata) : rdata_q;
    assign mem_addr    = addr_q[LB +: MEM_AW];

endmodule

// File: tb/tb_emulib_dmamodel_axi_responder.sv
// Directed bench for emulib_dmamodel_axi_responder with a behavioural SRAM model.
`timescale 1ns/1ps
module tb_emulib_dmamodel_axi_responder;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 64;
    localparam int unsigned IW  = 4;
    localparam int unsigned MAW = 16;
    localparam int unsigned SW  = DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic awvalid = 0, awready; logic [IW-1:0] awid = 0; logic [AW-1:0] awaddr = 0;
    logic [7:0] awlen = 0; logic [2:0] awsize = 0; logic [1:0] awburst = 0;
    logic wvalid = 0, wready; logic [DW-1:0] wdata = 0; logic [SW-1:0] wstrb = 0; logic wlast = 0;
    logic bvalid, bready = 0; logic [IW-1:0] bid; logic [1:0] bresp;
    logic arvalid = 0, arready; logic [IW-1:0] arid = 0; logic [AW-1:0] araddr = 0;
    logic [7:0] arlen = 0; logic [2:0] arsize = 0; logic [1:0] arburst = 0;
    logic rvalid, rready = 1; logic [IW-1:0] rid; logic [DW-1:0] rdata; logic [1:0] rresp; logic rlast;
    logic mem_en; logic [SW-1:0] mem_wstrb; logic [MAW-1:0] mem_addr; logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    emulib_dmamodel_axi_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MEM_AW(MAW)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awid(awid), .s_axi_awaddr(awaddr),
        .s_axi_awlen(awlen), .s_axi_awsize(awsize), .s_axi_awburst(awburst),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
        .s_axi_wlast(wlast),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bid(bid), .s_axi_bresp(bresp),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_arid(arid), .s_axi_araddr(araddr),
        .s_axi_arlen(arlen), .s_axi_arsize(arsize), .s_axi_arburst(arburst),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rid(rid), .s_axi_rdata(rdata),
        .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .mem_en(mem_en), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // SRAM model: byte-enabled writes, registered read data one cycle after mem_en
    logic [DW-1:0]  mem [0:(1<<MAW)-1];
    logic [MAW-1:0] wr_log[$];
    logic [MAW-1:0] rd_log[$];
    int en_cnt = 0;
    always @(posedge clk) begin
        if (mem_en) begin
            en_cnt++;
            if (mem_wstrb != '0) begin
                for (int b = 0; b < SW; b++)
                    if (mem_wstrb[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                wr_log.push_back(mem_addr);
            end else begin
                mem_rdata <= mem[mem_addr];
                rd_log.push_back(mem_addr);
            end
        end
    end

    int n_vec = 0;
    int n_err = 0;
    logic [DW-1:0] rd_data [16];
    logic [1:0]    rd_resp [16];
    logic          rd_last [16];
    logic [IW-1:0] rd_id   [16];
    int r_lat, r_gap;
    logic [IW-1:0] b_id;
    logic [1:0]    b_resp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int s);
        case (s)
            0:       return awready;
            1:       return arready;
            2:       return wready;
            3:       return bvalid;
            4:       return rvalid;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int s, input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sig(s) && n < 64);
        chk({tag, " seen"}, 64'(sig(s)), 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic set_aw(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        awid = id; awaddr = a; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    endtask

    task automatic set_ar(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        arid = id; araddr = a; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    endtask

    task automatic aw_issue(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        int n;
        set_aw(id, a, len, size, burst);
        wait_for(0, "awready", n);
        @(posedge clk);
        #1 awvalid = 1'b0;
    endtask

    task automatic ar_issue(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        int n;
        set_ar(id, a, len, size, burst);
        wait_for(1, "arready", n);
        @(posedge clk);
        #1 arvalid = 1'b0;
    endtask

    task automatic w_send(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic last);
        int n;
        wdata = d; wstrb = s; wlast = last; wvalid = 1'b1;
        wait_for(2, "wready", n);
        @(posedge clk);
        #1 wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic b_wait();
        int n;
        bready = 1'b1;
        wait_for(3, "bvalid", n);
        b_id = bid; b_resp = bresp;
        @(posedge clk);
        #1 bready = 1'b0;
    endtask

    // Collect len+1 beats; at beat 'hold' keep rready low for 5 cycles
    task automatic r_collect(input int len, input int hold);
        int n, e0;
        logic stable;
        for (int i = 0; i <= len; i++) begin
            if (i == hold) rready = 1'b0;
            wait_for(4, "rvalid", n);
            if (i == 0) r_lat = n;
            if (i == 1) r_gap = n;
            rd_data[i] = rdata; rd_resp[i] = rresp; rd_last[i] = rlast; rd_id[i] = rid;
            if (i == hold) begin
                e0 = en_cnt;
                stable = 1'b1;
                repeat (5) begin
                    @(negedge clk);
                    if ({rvalid, rdata, rid, rlast} !== {1'b1, rd_data[i], rd_id[i], rd_last[i]})
                        stable = 1'b0;
                end
                chk("bp payload stable", 64'(stable), 64'd1);
                chk("bp no extra mem_en", 64'(en_cnt), 64'(e0));
                rready = 1'b1;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int e0;
        logic seen;
        logic [MAW-1:0] wexp [4];
        logic [DW-1:0]  dexp [4];

        arvalid = 1'b1;
        #3;
        chk("reset ctl", 64'({awready, arready, wready, bvalid, rvalid, rlast, mem_en, mem_wstrb}), 64'd0);
        chk("reset rdata", rdata, 64'd0);
        arvalid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // INCR write 1..4 at 0x100
        wr_log.delete();
        aw_issue(4'd5, 32'h100, 8'd3, 3'd3, 2'b01);
        for (int i = 0; i < 4; i++) w_send(64'(i + 1), 8'hFF, i == 3);
        b_wait();
        chk("incr wr bid", 64'(b_id), 64'd5);
        chk("incr wr bresp", 64'(b_resp), 64'd0);
        chk("incr wr count", 64'(wr_log.size()), 64'd4);
        for (int i = 0; i < 4; i++) chk("incr wr addr", 64'(wr_log[i]), 64'(32'h20 + i));

        // INCR readback, with latency and throughput
        ar_issue(4'd6, 32'h100, 8'd3, 3'd3, 2'b01);
        r_collect(3, -1);
        chk("rd latency", 64'(r_lat), 64'd2);
        chk("rd beat gap", 64'(r_gap), 64'd2);
        for (int i = 0; i < 4; i++) begin
            chk("incr rd data", rd_data[i], 64'(i + 1));
            chk("incr rd last", 64'(rd_last[i]), 64'(i == 3));
            chk("incr rd resp", 64'(rd_resp[i]), 64'd0);
            chk("incr rd id", 64'(rd_id[i]), 64'd6);
        end

        // WRAP read from 0x118 in a 32-byte container
        rd_log.delete();
        ar_issue(4'd7, 32'h118, 8'd3, 3'd3, 2'b10);
        r_collect(3, -1);
        wexp = '{16'h23, 16'h20, 16'h21, 16'h22};
        dexp = '{64'd4, 64'd1, 64'd2, 64'd3};
        chk("wrap rd count", 64'(rd_log.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("wrap rd addr", 64'(rd_log[i]), 64'(wexp[i]));
            chk("wrap rd data", rd_data[i], dexp[i]);
        end

        // FIXED write, last beat with partial strobe
        wr_log.delete();
        aw_issue(4'd1, 32'h40, 8'd2, 3'd3, 2'b00);
        w_send(64'h1111_1111_1111_1111, 8'hFF, 1'b0);
        w_send(64'h2222_2222_2222_2222, 8'hFF, 1'b0);
        w_send(64'h3333_3333_3333_3333, 8'h0F, 1'b1);
        b_wait();
        chk("fixed bresp", 64'(b_resp), 64'd0);
        chk("fixed wr count", 64'(wr_log.size()), 64'd3);
        for (int i = 0; i < 3; i++) chk("fixed wr addr", 64'(wr_log[i]), 64'h8);
        ar_issue(4'd2, 32'h40, 8'd0, 3'd3, 2'b01);
        r_collect(0, -1);
        chk("fixed rd data", rd_data[0], 64'h2222_2222_3333_3333);
        chk("len0 rlast", 64'(rd_last[0]), 64'd1);

        // Early wlast on beat 1 of a 4-beat burst
        wr_log.delete();
        aw_issue(4'd3, 32'h200, 8'd3, 3'd3, 2'b01);
        w_send(64'hAA, 8'hFF, 1'b0);
        w_send(64'hBB, 8'hFF, 1'b1);
        b_wait();
        chk("early wlast bresp", 64'(b_resp), 64'd2);
        chk("early wlast writes", 64'(wr_log.size()), 64'd2);

        // Oversized beat: no memory access, SLVERR, zero data
        e0 = en_cnt;
        ar_issue(4'd4, 32'h100, 8'd1, 3'd4, 2'b01);
        r_collect(1, -1);
        for (int i = 0; i < 2; i++) begin
            chk("size err rresp", 64'(rd_resp[i]), 64'd2);
            chk("size err rdata", rd_data[i], 64'd0);
        end
        chk("size err mem_en", 64'(en_cnt), 64'(e0));

        // R backpressure on beat 1
        e0 = en_cnt;
        ar_issue(4'd8, 32'h100, 8'd3, 3'd3, 2'b01);
        r_collect(3, 1);
        for (int i = 0; i < 4; i++) chk("bp rd data", rd_data[i], 64'(i + 1));
        chk("bp total mem_en", 64'(en_cnt - e0), 64'd4);

        // Simultaneous AW/AR after reset: WRITE first, then READ
        do_reset();
        set_aw(4'd9, 32'h300, 8'd0, 3'd3, 2'b01);
        set_ar(4'd10, 32'h100, 8'd0, 3'd3, 2'b01);
        @(negedge clk);
        chk("arb1 awready", 64'(awready), 64'd1);
        chk("arb1 arready", 64'(arready), 64'd0);
        @(posedge clk);
        #1 awvalid = 1'b0;
        w_send(64'h55, 8'hFF, 1'b1);
        b_wait();
        chk("arb1 bid", 64'(b_id), 64'd9);
        set_aw(4'd11, 32'h308, 8'd0, 3'd3, 2'b01);
        @(negedge clk);
        chk("arb2 arready", 64'(arready), 64'd1);
        chk("arb2 awready", 64'(awready), 64'd0);
        @(posedge clk);
        #1 arvalid = 1'b0;
        @(negedge clk);
        chk("busy awready held", 64'(awready), 64'd0);
        r_collect(0, -1);
        chk("arb2 rd data", rd_data[0], 64'd1);
        chk("arb2 rid", 64'(rd_id[0]), 64'd10);
        @(negedge clk);
        chk("arb3 awready", 64'(awready), 64'd1);
        @(posedge clk);
        #1 awvalid = 1'b0;
        w_send(64'h66, 8'hFF, 1'b1);
        b_wait();
        chk("arb3 bid", 64'(b_id), 64'd11);

        // Reset in the middle of a write burst
        aw_issue(4'd12, 32'h400, 8'd3, 3'd3, 2'b01);
        w_send(64'h77, 8'hFF, 1'b0);
        wdata = 64'h88; wstrb = 8'hFF; wvalid = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("async rst ctl", 64'({awready, arready, wready, bvalid, rvalid, rlast, mem_en, mem_wstrb}), 64'd0);
        wvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bready = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bvalid || wready) seen = 1'b1;
        end
        bready = 1'b0;
        chk("no B after rst", 64'(seen), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/emulib_dmamodel_axi_responder.md
Name: emulib_dmamodel_axi_responder

Overview:
AXI4 slave responder that terminates the DMA model's AXI4 master port. It accepts AW/W/AR bursts and converts each beat into a single-word access on a synchronous SRAM-style backing port. It returns B and R responses with correct ID, last and response codes. Used as the memory-side endpoint in DMA-model benches and as the host-memory stub in emulation builds.

Parameters:
ADDR_WIDTH, 32, AXI byte-address width
DATA_WIDTH, 64, AXI/memory data width; power of two, 32..512
ID_WIDTH, 4, AXI ID width
MEM_AW, 16, memory word-address width; mem_addr = addr[MEM_AW+LB-1:LB], where LB = log2(DATA_WIDTH/8)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
s_axi_awvalid/awready  in/out  1/1  AW handshake
s_axi_awid/awaddr/awlen/awsize/awburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  AW payload
s_axi_wvalid/wready  in/out  1/1  W handshake
s_axi_wdata/wstrb/wlast  in  DATA_WIDTH/DATA_WIDTH/8/1  W payload
s_axi_bvalid/bready  out/in  1/1  B handshake
s_axi_bid/bresp  out  ID_WIDTH/2  B payload
s_axi_arvalid/arready  in/out  1/1  AR handshake
s_axi_arid/araddr/arlen/arsize/arburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  AR payload
s_axi_rvalid/rready  out/in  1/1  R handshake
s_axi_rid/rdata/rresp/rlast  out  ID_WIDTH/DATA_WIDTH/2/1  R payload
mem_en  out  1  memory access strobe
mem_wstrb  out  DATA_WIDTH/8  byte write enables; all zero means read
mem_addr  out  MEM_AW  word address
mem_wdata  out  DATA_WIDTH  write data
mem_rdata  in  DATA_WIDTH  read data, valid exactly 1 cycle after mem_en with mem_wstrb=0

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE, rr_last=READ. All valid/ready outputs 0, mem_en=0, mem_wstrb=0. All payload registers 0.
- FSM states: IDLE, WDATA, WRESP, RADDR, RDATA. One burst is in flight at a time; there is no read/write overlap.
- IDLE: awready and arready are driven combinationally from the arbiter.
  - Only one of awvalid/arvalid high: grant that channel.
  - Both high: grant the channel opposite to rr_last (round-robin).
  - On grant, latch id/addr/len/size/burst, clear beat counter and err flag, set rr_last to the granted channel, and go to WDATA or RADDR.
- Error checks at grant:
  - size > LB sets err; all beats then complete with no memory access.
  - burst=2'b11 sets err; address advances as INCR.
  - WRAP with len not in {1,3,7,15} sets err.
- Address step after each beat (byte address):
  - FIXED: address unchanged.
  - INCR: addr += 1<<size, ADDR_WIDTH wrap-around.
  - WRAP: container size = (len+1)<<size; low bits wrap within the aligned container, high bits held.
- WDATA: wready=1.
  - Each W handshake with beat<=len and err=0 drives mem_en=1, mem_wstrb=wstrb, mem_addr and mem_wdata in the same cycle. Zero-cycle write.
  - Beats with beat>len are accepted but not written, and set err.
  - On the wlast handshake: if beat!=len, set err. Go to WRESP.
- WRESP: bvalid=1, bid=latched id, bresp = err ? 2'b10 (SLVERR) : 2'b00. On bready, return to IDLE. bvalid is held stable until accepted.
- RADDR: mem_en=1 and mem_wstrb=0 for 1 cycle (suppressed if err), then go to RDATA.
- RDATA:
  - rdata is registered from mem_rdata on RDATA entry, or 0 if err.
  - rvalid=1, rid=latched id, rresp = err ? 2'b10 : 2'b00, rlast = (beat==len).
  - Payload is held stable while rvalid=1 and rready=0.
  - On handshake: if rlast, go to IDLE; else beat++, advance address, go to RADDR.
  - Throughput is 1 beat per 2 cycles. AR-accept to first rvalid is 2 cycles.
- len=0: single-beat burst. rlast=1 on the first beat; a W beat with wlast=1 completes normally.
- awvalid/arvalid arriving while busy: held off (ready=0) until the FSM returns to IDLE.
- Reset asserted mid-burst: the burst is abandoned; no B or R is generated after reset deasserts.

Test Plan:
- INCR write, awaddr=0x100, len=3, size=3, wstrb=0xFF, data 1..4 -> mem writes at word addr 0x20..0x23, then bresp=0 with the AW id. Readback at same address, len=3 -> rdata 1..4, rlast only on beat 3, rresp=0.
- WRAP read, araddr=0x118, len=3, size=3 -> mem_addr sequence 0x23, 0x20, 0x21, 0x22.
- FIXED write, len=2, addr=0x40 -> three writes all to word 0x8; the last wstrb=0x0F is honoured byte-wise.
- wlast asserted early on beat 1 of a len=3 burst -> bresp=2'b10, only 2 memory writes. Also: size=4 on a 64-bit bus read -> rresp=2'b10 on every beat, rdata=0, mem_en never asserted.
- AW and AR asserted in the same cycle, twice in succession -> first grant is WRITE (rr_last=READ after reset), second is READ.
- R backpressure: rready=0 for 5 cycles mid-burst -> rdata/rid/rlast stable, no extra mem_en. Also: rst pulse during WDATA -> all outputs 0 asynchronously, no bvalid afterwards.
